// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

   localparam int unsigned LAT_W = 4;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_DM = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Requester selection for mem_arbiter. Optional feature macro:
// MEM_ARB_ROUND_ROBIN_EN (tie goes to the requester not served last).
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic dm_req,
   input  logic mask_en,
   input  logic mask_id,
   input  logic last_grant,
   output logic win_id_c,
   output logic win_valid_c
);

   logic if_eff;
   logic dm_eff;

   // Mask the requester being acknowledged, then pick a winner
   always_comb begin
      if_eff      = if_req & ~(mask_en & (mask_id == REQ_IF));
      dm_eff      = dm_req & ~(mask_en & (mask_id == REQ_DM));
      win_valid_c = if_eff | dm_eff;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (if_eff && dm_eff) begin
         win_id_c = (last_grant == REQ_IF) ? REQ_DM : REQ_IF;
      end else begin
         win_id_c = dm_eff ? REQ_DM : REQ_IF;
      end
`else
      // Data first: the MEM-stage instruction is older
      win_id_c = dm_eff ? REQ_DM : REQ_IF;
`endif
   end

`ifndef MEM_ARB_ROUND_ROBIN_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by fetch and the MEM stage.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_lat_check
      $error("mem_arbiter: MEM_LATENCY must be in 1..15");
   end

   state_t           state;
   state_t           state_nxt;
   logic             take_c;
   logic             cap_c;
   logic             cur_id;
   logic             cur_we;
   logic [LAT_W-1:0] cnt;
   logic             last_grant;
   logic             win_id_c;
   logic             win_valid_c;

   mem_arb_pick u_pick (
      .if_req      (if_req),
      .dm_req      (dm_req),
      .mask_en     (state == RESP),
      .mask_id     (cur_id),
      .last_grant  (last_grant),
      .win_id_c    (win_id_c),
      .win_valid_c (win_valid_c)
   );

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus latch/capture strobes
   always_comb begin
      state_nxt = state;
      take_c    = 1'b0;
      cap_c     = 1'b0;
      unique case (state)
         IDLE: begin
            if (win_valid_c) begin
               take_c    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (cnt == LAT_W'(1)) begin
               cap_c     = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (win_valid_c) begin
               take_c    = 1'b1;
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction latch, memory port, latency counter and responses
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_id    <= REQ_IF;
         cur_we    <= 1'b0;
         cnt       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
      end else begin
         mem_en <= take_c;
         mem_we <= take_c & (win_id_c == REQ_DM) & dm_we;
         if (take_c) begin
            cur_id <= win_id_c;
            cur_we <= (win_id_c == REQ_DM) & dm_we;
            if (win_id_c == REQ_DM) begin
               mem_addr  <= dm_addr;
               mem_wdata <= dm_wdata;
            end else begin
               mem_addr  <= if_addr;
            end
         end
         if (state == ISSUE) begin
            cnt <= LAT_W'(MEM_LATENCY);
         end else if (state == WAIT) begin
            cnt <= cnt - LAT_W'(1);
         end
         if_ack <= cap_c & (cur_id == REQ_IF);
         dm_ack <= cap_c & (cur_id == REQ_DM);
         if (cap_c && cur_id == REQ_IF) begin
            if_rdata <= mem_rdata;
         end
         // Stores leave the load data register untouched
         if (cap_c && cur_id == REQ_DM && !cur_we) begin
            dm_rdata <= mem_rdata;
         end
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Remember who was issued last for tie breaking
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= REQ_IF;
      end else if (state == ISSUE) begin
         last_grant <= cur_id;
      end
   end
`else
   assign last_grant = REQ_IF;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (L=2 main instance,
// plus L=1 and L=15 instances for latency corners).
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam logic [31:0] TIE_ADDR = 32'h80;
`else
   localparam logic [31:0] TIE_ADDR = 32'hC0;
`endif

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_mem;

   logic        if_req1, if_ack1, dm_ack1, mem_en1, mem_we1, stall_if1, stall_mem1;
   logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        if_req15, if_ack15, dm_ack15, mem_en15, mem_we15, stall_if15, stall_mem15;
   logic [31:0] if_rdata15, dm_rdata15, mem_addr15, mem_wdata15, mem_rdata15;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_arr [0:255];

   always @(posedge clk) if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
   assign mem_rdata   = mem_arr[mem_addr[9:2]];
   assign mem_rdata1  = mem_arr[mem_addr1[9:2]];
   assign mem_rdata15 = mem_arr[mem_addr15[9:2]];

   mem_arbiter #(.MEM_LATENCY(2), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ack(if_ack), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem));

   mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_l1 (
      .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr), .if_rdata(if_rdata1),
      .if_ack(if_ack1), .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0),
      .dm_wdata(32'h0), .dm_rdata(dm_rdata1), .dm_ack(dm_ack1), .mem_en(mem_en1),
      .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1));

   mem_arbiter #(.MEM_LATENCY(15), .ADDR_W(32), .DATA_W(32)) dut_l15 (
      .clk(clk), .rst(rst), .if_req(if_req15), .if_addr(if_addr), .if_rdata(if_rdata15),
      .if_ack(if_ack15), .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0),
      .dm_wdata(32'h0), .dm_rdata(dm_rdata15), .dm_ack(dm_ack15), .mem_en(mem_en15),
      .mem_we(mem_we15), .mem_addr(mem_addr15), .mem_wdata(mem_wdata15),
      .mem_rdata(mem_rdata15), .stall_if(stall_if15), .stall_mem(stall_mem15));

   task automatic do_reset;
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_req1 = 1'b0; if_req15 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if ({mem_en, mem_we, if_ack, dm_ack, stall_if, stall_mem} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b exp 000000",
                  {mem_en, mem_we, if_ack, dm_ack, stall_if, stall_mem});
      end
      checks++;
      if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h %h exp all 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
   endtask

   task automatic test_single_fetch;
      if_addr = 32'h40; if_req = 1'b1;
      #1;
      checks++;
      if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_t0: got %b exp 1", stall_if); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++;
         if (mem_en !== 1'(k == 1)) begin errors++; $display("FAIL fetch_mem_en k=%0d: got %b", k, mem_en); end
         checks++;
         if (if_ack !== 1'(k == 4)) begin errors++; $display("FAIL fetch_ack k=%0d: got %b", k, if_ack); end
         checks++;
         if (stall_if !== 1'(k < 4)) begin errors++; $display("FAIL fetch_stall k=%0d: got %b", k, stall_if); end
         if (k == 1) begin
            checks++;
            if (mem_addr !== 32'h40) begin errors++; $display("FAIL fetch_addr: got %h exp 00000040", mem_addr); end
         end
      end
      checks++;
      if (if_rdata !== 32'h1234_5678) begin errors++; $display("FAIL fetch_rdata: got %h exp 12345678", if_rdata); end
      if_req = 1'b0;
      @(negedge clk);
      checks++;
      if (if_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_pulse: got %b exp 0", if_ack); end
   endtask

   task automatic test_store;
      dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_we = 1'b1; dm_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++;
         if (mem_we !== 1'(k == 1)) begin errors++; $display("FAIL store_mem_we k=%0d: got %b", k, mem_we); end
         checks++;
         if (dm_ack !== 1'(k == 4)) begin errors++; $display("FAIL store_ack k=%0d: got %b", k, dm_ack); end
         if (k == 1) begin
            checks++;
            if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
               errors++; $display("FAIL store_port: got %h %h exp 00000100 deadbeef", mem_addr, mem_wdata);
            end
         end
      end
      checks++;
      if (dm_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata_kept: got %h exp 00000000", dm_rdata); end
      dm_req = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      dm_req = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (dm_ack !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL load_back: got ack=%b %h exp ack=1 deadbeef", dm_ack, dm_rdata);
      end
      dm_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_contention;
      do_reset();
      if_addr = 32'h80; dm_addr = 32'hC0; dm_we = 1'b0;
      if_req = 1'b1; dm_req = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1 || k == 5) begin
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== ((k == 1) ? 32'hC0 : 32'h80)) begin
               errors++; $display("FAIL contend_issue k=%0d: got en=%b %h", k, mem_en, mem_addr);
            end
         end
         if (k == 4) begin
            checks++;
            if (dm_ack !== 1'b1 || if_ack !== 1'b0 || dm_rdata !== 32'hBBBB_0002 || stall_if !== 1'b1) begin
               errors++; $display("FAIL contend_dm_ack: got %b%b%b %h exp 101 bbbb0002", dm_ack, if_ack, stall_if, dm_rdata);
            end
            dm_req = 1'b0;
         end
         if (k == 8) begin
            checks++;
            if (if_ack !== 1'b1 || if_rdata !== 32'hAAAA_0001) begin
               errors++; $display("FAIL contend_if_ack: got %b %h exp 1 aaaa0001", if_ack, if_rdata);
            end
            if_req = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int issue_k [4];
      logic [31:0] issue_a [4];
      int n;
      do_reset();
      if_addr = 32'h80; dm_addr = 32'hC0; dm_we = 1'b0;
      if_req = 1'b1; dm_req = 1'b1;
      n = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (mem_en && n < 4) begin issue_k[n] = k; issue_a[n] = mem_addr; n++; end
      end
      if_req = 1'b0; dm_req = 1'b0;
      checks++;
      if (n != 4) begin errors++; $display("FAIL b2b_count: got %0d exp 4", n); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (issue_k[i] != 1 + 4 * i || issue_a[i] !== ((i % 2 == 0) ? 32'hC0 : 32'h80)) begin
            errors++; $display("FAIL b2b_issue%0d: got k=%0d %h", i, issue_k[i], issue_a[i]);
         end
      end
      repeat (6) @(negedge clk);
      if_req = 1'b1;
      n = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (mem_en && n < 4) begin issue_k[n] = k; n++; end
      end
      if_req = 1'b0;
      checks++;
      if (n < 2 || issue_k[0] != 1 || issue_k[1] != 6) begin
         errors++; $display("FAIL same_req_period: got n=%0d k0=%0d k1=%0d exp 1 6", n, issue_k[0], issue_k[1]);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_tie;
      logic if_done, dm_done;
      do_reset();
      if_addr = 32'h80; dm_addr = 32'hC0; dm_we = 1'b0;
      dm_req = 1'b1;
      repeat (4) @(negedge clk);
      dm_req = 1'b0;
      @(negedge clk);
      if_req = 1'b1; dm_req = 1'b1;
      if_done = 1'b0; dm_done = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== TIE_ADDR) begin
               errors++; $display("FAIL tie_winner: got en=%b %h exp %h", mem_en, mem_addr, TIE_ADDR);
            end
         end
         if (if_ack) begin if_done = 1'b1; if_req = 1'b0; end
         if (dm_ack) begin dm_done = 1'b1; dm_req = 1'b0; end
      end
      if_req = 1'b0; dm_req = 1'b0;
      checks++;
      if (!(if_done && dm_done)) begin errors++; $display("FAIL tie_both_acked: got if=%b dm=%b", if_done, dm_done); end
   endtask

   task automatic test_reset_mid;
      if_addr = 32'h40; if_req = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_en, mem_we, if_ack, dm_ack} !== 4'b0 || {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
         errors++; $display("FAIL rst_mid_outputs: got %b %h %h %h %h", {mem_en, mem_we, if_ack, dm_ack},
                            mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
      rst = 1'b0; if_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (if_ack !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_ack: got ack=%b en=%b exp 0 0", if_ack, mem_en);
         end
      end
      if_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++;
         if (if_ack !== 1'(k == 4)) begin errors++; $display("FAIL rst_mid_new_ack k=%0d: got %b", k, if_ack); end
      end
      checks++;
      if (if_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rst_mid_rdata: got %h exp 12345678", if_rdata); end
      if_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_latency;
      int k1, k15;
      logic [31:0] d1;
      do_reset();
      if_addr = 32'h40; if_req1 = 1'b1; if_req15 = 1'b1;
      k1 = 0; k15 = 0; d1 = 32'h0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (if_ack1 && k1 == 0) begin k1 = k; d1 = if_rdata1; if_req1 = 1'b0; end
         if (if_ack15 && k15 == 0) begin k15 = k; if_req15 = 1'b0; end
      end
      if_req1 = 1'b0; if_req15 = 1'b0;
      checks++;
      if (k1 != 3 || d1 !== 32'h1234_5678) begin errors++; $display("FAIL lat1_ack: got k=%0d %h exp 3 12345678", k1, d1); end
      checks++;
      if (k15 != 17) begin errors++; $display("FAIL lat15_ack: got k=%0d exp 17", k15); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
      mem_arr[16] = 32'h1234_5678;
      mem_arr[32] = 32'hAAAA_0001;
      mem_arr[48] = 32'hBBBB_0002;
      if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
      do_reset();
      test_reset();
      test_single_fetch();
      test_store();
      test_contention();
      test_back_to_back();
      test_tie();
      test_reset_mid();
      test_latency();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
